cam_match_encoder: RTL and testbench

Converts a CAM search result (DEPTH match lines, one per entry, sampled when the search completes) into a stream of binary entry indices, lowest index first. It is the inverse of the CAM index decoder: it sits on the CAM search return path, captures the match vector, and emits one index per handshake until all matches are reported, or emits a single miss result. The output is a valid/ready stream toward the CAM control/lookup logic.

---
 rtl/cam_match_encoder.sv | 108 ++++++++++
 tb/tb_cam_match_encoder.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/cam_match_encoder.sv
// Turns a captured CAM match vector into a valid/ready stream of entry indices,
// lowest index first, or into a single miss result when nothing matched.
//
// state  | meaning
// IDLE   | waiting for a search result; search_ready_o high
// EMIT   | reporting captured matches one per handshake
module cam_match_encoder #(
  parameter int ADDR_WIDTH = 5,
  parameter int DEPTH      = 1 << ADDR_WIDTH
) (
  input  logic                  clk_i,
  input  logic                  reset_i,
  input  logic                  search_valid_i,
  output logic                  search_ready_o,
  input  logic [DEPTH-1:0]      match_lines_i,
  output logic                  result_valid_o,
  input  logic                  result_ready_i,
  output logic                  result_hit_o,
  output logic [ADDR_WIDTH-1:0] result_index_o,
  output logic                  result_last_o,
  output logic                  multi_match_o
);

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_EMIT = 1'b1;

  localparam logic [DEPTH-1:0] ONE = DEPTH'(1);

  logic [0:0]            state_q, state_d;
  logic [DEPTH-1:0]      pending_q, pending_d;
  logic                  multi_q, multi_d;
  logic                  valid_q, valid_d;
  logic                  hit_q, hit_d;
  logic [ADDR_WIDTH-1:0] index_q, index_d;
  logic                  last_q, last_d;

  function automatic logic [ADDR_WIDTH-1:0] lowest_set(input logic [DEPTH-1:0] v);
    logic [ADDR_WIDTH-1:0] idx;
    idx = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (v[i]) idx = ADDR_WIDTH'(i);
    end
    return idx;
  endfunction

  always_comb begin
    state_d   = state_q;
    pending_d = pending_q;
    multi_d   = multi_q;
    case (state_q)
      S_IDLE: begin
        if (search_valid_i) begin
          pending_d = match_lines_i;
          multi_d   = |(match_lines_i & (match_lines_i - ONE));
          state_d   = S_EMIT;
        end
      end
      default: begin
        if (valid_q && result_ready_i) begin
          if (last_q) begin
            state_d   = S_IDLE;
            pending_d = '0;
            multi_d   = 1'b0;
          end else begin
            // drop the lowest set bit, which is the one just reported
            pending_d = pending_q & (pending_q - ONE);
          end
        end
      end
    endcase
  end

  // result fields are precomputed from the next pending value so they leave flops
  always_comb begin
    valid_d = (state_d == S_EMIT);
    hit_d   = valid_d && (|pending_d);
    index_d = hit_d ? lowest_set(pending_d) : '0;
    last_d  = valid_d && ~(|(pending_d & (pending_d - ONE)));
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q   <= S_IDLE;
      pending_q <= '0;
      multi_q   <= 1'b0;
      valid_q   <= 1'b0;
      hit_q     <= 1'b0;
      index_q   <= '0;
      last_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
      multi_q   <= multi_d;
      valid_q   <= valid_d;
      hit_q     <= hit_d;
      index_q   <= index_d;
      last_q    <= last_d;
    end
  end

  assign search_ready_o = (state_q == S_IDLE);
  assign result_valid_o = valid_q;
  assign result_hit_o   = hit_q;
  assign result_index_o = index_q;
  assign result_last_o  = last_q;
  assign multi_match_o  = multi_q;

endmodule

// File: tb/tb_cam_match_encoder.sv
// Scoreboard bench for cam_match_encoder: expected results are queued when a
// search is accepted and compared on every cycle the DUT presents a result.
module tb_cam_match_encoder;

  localparam int AW = 5;
  localparam int DP = 1 << AW;

  logic          clk_i = 1'b0;
  logic          reset_i;
  logic          search_valid_i;
  logic          search_ready_o;
  logic [DP-1:0] match_lines_i;
  logic          result_valid_o;
  logic          result_ready_i;
  logic          result_hit_o;
  logic [AW-1:0] result_index_o;
  logic          result_last_o;
  logic          multi_match_o;

  typedef struct {
    logic          hit;
    logic [AW-1:0] idx;
    logic          last;
    logic          multi;
  } exp_t;

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_errors = 0;

  cam_match_encoder #(.ADDR_WIDTH(AW), .DEPTH(DP)) dut (
    .clk_i          (clk_i),
    .reset_i        (reset_i),
    .search_valid_i (search_valid_i),
    .search_ready_o (search_ready_o),
    .match_lines_i  (match_lines_i),
    .result_valid_o (result_valid_o),
    .result_ready_i (result_ready_i),
    .result_hit_o   (result_hit_o),
    .result_index_o (result_index_o),
    .result_last_o  (result_last_o),
    .multi_match_o  (multi_match_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic push_expected(input logic [DP-1:0] v);
    exp_t e;
    int   total;
    int   seen;
    total = 0;
    for (int i = 0; i < DP; i++) if (v[i]) total++;
    if (total == 0) begin
      e.hit = 1'b0; e.idx = '0; e.last = 1'b1; e.multi = 1'b0;
      sb_q.push_back(e);
    end else begin
      seen = 0;
      for (int i = 0; i < DP; i++) begin
        if (v[i]) begin
          seen++;
          e.hit = 1'b1; e.idx = AW'(i); e.last = (seen == total); e.multi = (total >= 2);
          sb_q.push_back(e);
        end
      end
    end
  endtask

  // mode 0: always ready, 1: random ready, 2: stall 3 cycles with search_valid pulses
  task automatic do_search(input string name, input logic [DP-1:0] v, input int mode);
    int   cyc;
    exp_t e;
    check_val({name, ":ready_before"}, 64'(search_ready_o), 64'd1);
    search_valid_i = 1'b1;
    match_lines_i  = v;
    result_ready_i = 1'b0;
    push_expected(v);
    @(posedge clk_i);
    @(negedge clk_i);
    search_valid_i = 1'b0;
    match_lines_i  = ~v;
    check_val({name, ":first_latency"}, 64'(result_valid_o), 64'd1);
    check_val({name, ":ready_low"}, 64'(search_ready_o), 64'd0);
    cyc = 0;
    while (sb_q.size() > 0 && cyc < 300) begin
      case (mode)
        0: result_ready_i = 1'b1;
        1: result_ready_i = 1'($urandom_range(0, 1));
        default: begin
          result_ready_i = (cyc >= 3);
          search_valid_i = (cyc < 3);
          match_lines_i  = 32'h0000_0F00;
        end
      endcase
      if (!result_valid_o) begin
        check_val({name, ":bubble"}, 64'(result_valid_o), 64'd1);
      end else begin
        e = sb_q[0];
        check_val({name, ":hit"},   64'(result_hit_o),   64'(e.hit));
        check_val({name, ":index"}, 64'(result_index_o), 64'(e.idx));
        check_val({name, ":last"},  64'(result_last_o),  64'(e.last));
        check_val({name, ":multi"}, 64'(multi_match_o),  64'(e.multi));
        if (result_ready_i) void'(sb_q.pop_front());
      end
      @(negedge clk_i);
      cyc++;
    end
    search_valid_i = 1'b0;
    result_ready_i = 1'b0;
    if (sb_q.size() > 0) begin
      check_val({name, ":timeout"}, 64'(sb_q.size()), 64'd0);
      sb_q.delete();
    end
    check_val({name, ":idle_ready"}, 64'(search_ready_o), 64'd1);
    check_val({name, ":idle_valid"}, 64'(result_valid_o), 64'd0);
    check_val({name, ":idle_multi"}, 64'(multi_match_o),  64'd0);
  endtask

  initial begin
    reset_i        = 1'b1;
    search_valid_i = 1'b0;
    match_lines_i  = '0;
    result_ready_i = 1'b0;
    #2;
    check_val("rst:ready", 64'(search_ready_o), 64'd1);
    check_val("rst:valid", 64'(result_valid_o), 64'd0);
    check_val("rst:hit",   64'(result_hit_o),   64'd0);
    check_val("rst:index", 64'(result_index_o), 64'd0);
    check_val("rst:last",  64'(result_last_o),  64'd0);
    check_val("rst:multi", 64'(multi_match_o),  64'd0);
    @(negedge clk_i);
    reset_i = 1'b0;
    @(negedge clk_i);

    // reset asserted mid-search discards everything asynchronously
    search_valid_i = 1'b1;
    match_lines_i  = 32'h0000_00F0;
    @(posedge clk_i);
    @(negedge clk_i);
    search_valid_i = 1'b0;
    check_val("midrst:in_emit", 64'(result_valid_o), 64'd1);
    check_val("midrst:multi_set", 64'(multi_match_o), 64'd1);
    #2 reset_i = 1'b1;
    #1;
    check_val("midrst:ready", 64'(search_ready_o), 64'd1);
    check_val("midrst:valid", 64'(result_valid_o), 64'd0);
    check_val("midrst:hit",   64'(result_hit_o),   64'd0);
    check_val("midrst:index", 64'(result_index_o), 64'd0);
    check_val("midrst:last",  64'(result_last_o),  64'd0);
    check_val("midrst:multi", 64'(multi_match_o),  64'd0);
    @(negedge clk_i);
    reset_i = 1'b0;
    @(negedge clk_i);
    check_val("postrst:ready", 64'(search_ready_o), 64'd1);
    check_val("postrst:valid", 64'(result_valid_o), 64'd0);

    do_search("single",   32'h0000_0100, 0);
    do_search("miss",     32'h0000_0000, 0);
    do_search("order",    32'h8000_0011, 0);
    do_search("backpres", 32'h0000_000C, 2);
    do_search("full",     32'hFFFF_FFFF, 1);
    do_search("top_only", 32'h8000_0000, 1);
    for (int k = 0; k < 6; k++) begin
      do_search("rand", DP'($urandom), 1);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
